// File: rtl/wb_arbiter.sv
// Multi-source writeback arbiter: per-channel result FIFOs feeding one registered register-file write port.
// Define WB_ARB_RR_EN for round-robin arbitration; otherwise the lowest-index non-empty channel wins.
module wb_arbiter #(
  parameter int NUM_SRC    = 4,
  parameter int XLEN       = 32,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    flush,
  input  logic                    stall_i,
  input  logic [NUM_SRC-1:0]      src_valid_i,
  output logic [NUM_SRC-1:0]      src_ready_o,
  input  logic [NUM_SRC*32-1:0]   src_pc_i,
  input  logic [NUM_SRC*5-1:0]    src_rd_i,
  input  logic [NUM_SRC-1:0]      src_freg_i,
  input  logic [NUM_SRC-1:0]      src_exc_i,
  input  logic [NUM_SRC*XLEN-1:0] src_data_i,
  output logic                    pc_valid_o,
  output logic [31:0]             pc_o,
  output logic [4:0]              rd_o,
  output logic [XLEN-1:0]         wb_data_o,
  output logic                    exc_o,
  output logic                    reg_wr_en_o,
  output logic                    freg_wr_en_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int SW = $clog2(NUM_SRC);

  logic [31:0]     pc_mem   [NUM_SRC][FIFO_DEPTH];
  logic [4:0]      rd_mem   [NUM_SRC][FIFO_DEPTH];
  logic            freg_mem [NUM_SRC][FIFO_DEPTH];
  logic            exc_mem  [NUM_SRC][FIFO_DEPTH];
  logic [XLEN-1:0] data_mem [NUM_SRC][FIFO_DEPTH];

  logic [AW-1:0] wr_ptr [NUM_SRC];
  logic [AW-1:0] rd_ptr [NUM_SRC];
  logic [CW-1:0] count  [NUM_SRC];

  logic [NUM_SRC-1:0] full;
  logic [NUM_SRC-1:0] not_empty;
  logic [NUM_SRC-1:0] push;
  logic [NUM_SRC-1:0] pop;
  logic               grant_en;
  logic               gnt_any;
  logic [SW-1:0]      gnt_idx;

  logic            valid_q;
  logic [31:0]     pc_q;
  logic [4:0]      rd_q;
  logic            freg_q;
  logic            exc_q;
  logic [XLEN-1:0] data_q;

  assign grant_en = ~stall_i & ~flush;

  // Ready reflects occupancy only; a pop in the same cycle does not free a slot early.
  always_comb begin
    full      = '0;
    not_empty = '0;
    push      = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      full[k]      = (count[k] == CW'(FIFO_DEPTH));
      not_empty[k] = (count[k] != '0);
      push[k]      = src_valid_i[k] & ~full[k] & ~flush;
    end
  end

  assign src_ready_o = ~full;

`ifdef WB_ARB_RR_EN
  logic [SW-1:0] rr_ptr;
  logic [SW-1:0] cand;
  int            j;

  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    j       = 0;
    for (int i = 0; i < NUM_SRC; i++) begin
      j = int'(rr_ptr) + i;
      if (j >= NUM_SRC) j = j - NUM_SRC;
      cand = SW'(j);
      if (grant_en && !gnt_any && not_empty[cand]) begin
        gnt_any = 1'b1;
        gnt_idx = cand;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= '0;
    end else if (flush) begin
      rr_ptr <= '0;
    end else if (gnt_any) begin
      rr_ptr <= (gnt_idx == SW'(NUM_SRC - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end
`else
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (grant_en && !gnt_any && not_empty[i]) begin
        gnt_any = 1'b1;
        gnt_idx = SW'(i);
      end
    end
  end
`endif

  always_comb begin
    pop = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      pop[k] = gnt_any && (gnt_idx == SW'(k));
    end
  end

  // Pointers wrap naturally because FIFO_DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_SRC; k++) begin
        wr_ptr[k] <= '0;
        rd_ptr[k] <= '0;
        count[k]  <= '0;
      end
    end else if (flush) begin
      for (int k = 0; k < NUM_SRC; k++) begin
        wr_ptr[k] <= '0;
        rd_ptr[k] <= '0;
        count[k]  <= '0;
      end
    end else begin
      for (int k = 0; k < NUM_SRC; k++) begin
        if (push[k]) wr_ptr[k] <= wr_ptr[k] + 1'b1;
        if (pop[k])  rd_ptr[k] <= rd_ptr[k] + 1'b1;
        case ({push[k], pop[k]})
          2'b10:   count[k] <= count[k] + 1'b1;
          2'b01:   count[k] <= count[k] - 1'b1;
          default: count[k] <= count[k];
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int k = 0; k < NUM_SRC; k++) begin
      if (push[k]) begin
        pc_mem[k][wr_ptr[k]]   <= src_pc_i[32*k +: 32];
        rd_mem[k][wr_ptr[k]]   <= src_rd_i[5*k +: 5];
        freg_mem[k][wr_ptr[k]] <= src_freg_i[k];
        exc_mem[k][wr_ptr[k]]  <= src_exc_i[k];
        data_mem[k][wr_ptr[k]] <= src_data_i[XLEN*k +: XLEN];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      pc_q    <= '0;
      rd_q    <= '0;
      freg_q  <= 1'b0;
      exc_q   <= 1'b0;
      data_q  <= '0;
    end else if (flush) begin
      valid_q <= 1'b0;
      freg_q  <= 1'b0;
      exc_q   <= 1'b0;
    end else if (!stall_i) begin
      valid_q <= gnt_any;
      if (gnt_any) begin
        pc_q   <= pc_mem[gnt_idx][rd_ptr[gnt_idx]];
        rd_q   <= rd_mem[gnt_idx][rd_ptr[gnt_idx]];
        freg_q <= freg_mem[gnt_idx][rd_ptr[gnt_idx]];
        exc_q  <= exc_mem[gnt_idx][rd_ptr[gnt_idx]];
        data_q <= data_mem[gnt_idx][rd_ptr[gnt_idx]];
      end
    end
  end

  assign pc_valid_o   = valid_q;
  assign pc_o         = pc_q;
  assign rd_o         = rd_q;
  assign wb_data_o    = data_q;
  assign exc_o        = exc_q;
  // x0 is hardwired to zero, so integer writes to it are dropped; f0 is a real register.
  assign reg_wr_en_o  = valid_q & ~exc_q & ~freg_q & (rd_q != 5'd0);
  assign freg_wr_en_o = valid_q & ~exc_q & freg_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter with NUM_SRC=4, XLEN=32, FIFO_DEPTH=2.
module tb_wb_arbiter;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         flush;
  logic         stall;
  logic [3:0]   src_valid;
  logic [3:0]   src_ready;
  logic [127:0] src_pc;
  logic [19:0]  src_rd;
  logic [3:0]   src_freg;
  logic [3:0]   src_exc;
  logic [127:0] src_data;
  logic         pc_valid;
  logic [31:0]  pc;
  logic [4:0]   rd;
  logic [31:0]  wb_data;
  logic         exc;
  logic         reg_wr_en;
  logic         freg_wr_en;

  int total = 0;
  int bad   = 0;

  wb_arbiter #(.NUM_SRC(4), .XLEN(32), .FIFO_DEPTH(2)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush        (flush),
    .stall_i      (stall),
    .src_valid_i  (src_valid),
    .src_ready_o  (src_ready),
    .src_pc_i     (src_pc),
    .src_rd_i     (src_rd),
    .src_freg_i   (src_freg),
    .src_exc_i    (src_exc),
    .src_data_i   (src_data),
    .pc_valid_o   (pc_valid),
    .pc_o         (pc),
    .rd_o         (rd),
    .wb_data_o    (wb_data),
    .exc_o        (exc),
    .reg_wr_en_o  (reg_wr_en),
    .freg_wr_en_o (freg_wr_en)
  );

  always #5 clk = ~clk;

  task automatic clear_src();
    src_valid = '0;
    src_pc    = '0;
    src_rd    = '0;
    src_freg  = '0;
    src_exc   = '0;
    src_data  = '0;
  endtask

  task automatic set_src(input int ch, input logic [31:0] p, input logic [4:0] r,
                         input logic f, input logic e, input logic [31:0] d);
    src_valid[ch]        = 1'b1;
    src_pc[32*ch +: 32]  = p;
    src_rd[5*ch +: 5]    = r;
    src_freg[ch]         = f;
    src_exc[ch]          = e;
    src_data[32*ch +: 32] = d;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    flush = 1'b0;
    stall = 1'b0;
    clear_src();
    #12;
    total++;
    if ({pc_valid, exc, reg_wr_en, freg_wr_en, pc, rd, wb_data} !== 72'd0) begin
      bad++;
      $display("FAIL reset_outputs got valid=%0b exc=%0b pc=%h rd=%0d data=%h want all zero",
               pc_valid, exc, pc, rd, wb_data);
    end
    total++;
    if (src_ready !== 4'b1111) begin
      bad++; $display("FAIL reset_ready got=%b want=1111", src_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_basic();
    set_src(2, 32'h0000_0100, 5'd5, 1'b0, 1'b0, 32'h0000_1234);
    step();
    clear_src();
    total++;
    if (pc_valid !== 1'b0) begin
      bad++; $display("FAIL basic_no_bypass got=%0b want=0", pc_valid);
    end
    total++;
    if (src_ready !== 4'b1111) begin
      bad++; $display("FAIL basic_ready_one_entry got=%b want=1111", src_ready);
    end
    step();
    total++;
    if ({pc_valid, reg_wr_en, freg_wr_en, exc} !== 4'b1100) begin
      bad++; $display("FAIL basic_flags got v/reg/freg/exc=%b want=1100", {pc_valid, reg_wr_en, freg_wr_en, exc});
    end
    total++;
    if (rd !== 5'd5) begin
      bad++; $display("FAIL basic_rd got=%0d want=5", rd);
    end
    total++;
    if (wb_data !== 32'h0000_1234) begin
      bad++; $display("FAIL basic_data got=%h want=00001234", wb_data);
    end
    total++;
    if (pc !== 32'h0000_0100) begin
      bad++; $display("FAIL basic_pc got=%h want=00000100", pc);
    end
    step();
    total++;
    if (pc_valid !== 1'b0) begin
      bad++; $display("FAIL basic_idle got=%0b want=0", pc_valid);
    end
  endtask

  task automatic test_x0_fp();
    set_src(0, 32'h0000_0200, 5'd0, 1'b0, 1'b0, 32'h0000_AAAA);
    step();
    clear_src();
    step();
    total++;
    if ({pc_valid, reg_wr_en, freg_wr_en} !== 3'b100) begin
      bad++; $display("FAIL x0_suppress got v/reg/freg=%b want=100", {pc_valid, reg_wr_en, freg_wr_en});
    end
    total++;
    if (wb_data !== 32'h0000_AAAA) begin
      bad++; $display("FAIL x0_data got=%h want=0000aaaa", wb_data);
    end
    set_src(1, 32'h0000_0204, 5'd0, 1'b1, 1'b0, 32'h3F80_0000);
    step();
    clear_src();
    step();
    total++;
    if ({pc_valid, reg_wr_en, freg_wr_en} !== 3'b101) begin
      bad++; $display("FAIL f0_write got v/reg/freg=%b want=101", {pc_valid, reg_wr_en, freg_wr_en});
    end
    total++;
    if (wb_data !== 32'h3F80_0000) begin
      bad++; $display("FAIL f0_data got=%h want=3f800000", wb_data);
    end
    step();
  endtask

  task automatic test_exception();
    set_src(3, 32'h0000_0300, 5'd7, 1'b0, 1'b1, 32'h0000_DEAD);
    step();
    clear_src();
    step();
    total++;
    if ({pc_valid, exc, reg_wr_en, freg_wr_en} !== 4'b1100) begin
      bad++; $display("FAIL exc_flags got v/exc/reg/freg=%b want=1100", {pc_valid, exc, reg_wr_en, freg_wr_en});
    end
    total++;
    if (pc !== 32'h0000_0300) begin
      bad++; $display("FAIL exc_pc got=%h want=00000300", pc);
    end
    step();
  endtask

  task automatic test_backpressure();
    stall = 1'b1;
    set_src(3, 32'h0000_0400, 5'd9, 1'b0, 1'b0, 32'h0000_0011);
    step();
    set_src(3, 32'h0000_0404, 5'd9, 1'b0, 1'b0, 32'h0000_0022);
    step();
    total++;
    if (src_ready[3] !== 1'b0) begin
      bad++; $display("FAIL bp_full_ready got=%0b want=0", src_ready[3]);
    end
    total++;
    if (pc_valid !== 1'b0) begin
      bad++; $display("FAIL bp_stall_blocks_grant got=%0b want=0", pc_valid);
    end
    set_src(3, 32'h0000_0408, 5'd9, 1'b0, 1'b0, 32'h0000_0033);
    step();
    total++;
    if (src_ready !== 4'b0111) begin
      bad++; $display("FAIL bp_still_full got=%b want=0111", src_ready);
    end
    clear_src();
    stall = 1'b0;
    step();
    total++;
    if ({pc_valid, wb_data} !== {1'b1, 32'h0000_0011}) begin
      bad++; $display("FAIL bp_first got v=%0b data=%h want v=1 data=00000011", pc_valid, wb_data);
    end
    step();
    total++;
    if ({pc_valid, wb_data} !== {1'b1, 32'h0000_0022}) begin
      bad++; $display("FAIL bp_second got v=%0b data=%h want v=1 data=00000022", pc_valid, wb_data);
    end
    step();
    total++;
    if (pc_valid !== 1'b0) begin
      bad++; $display("FAIL bp_third_dropped got v=%0b data=%h want v=0", pc_valid, wb_data);
    end
  endtask

  task automatic test_arbitration();
    logic [31:0] exp_q [8];
`ifdef WB_ARB_RR_EN
    exp_q = '{32'h000, 32'h100, 32'h200, 32'h300, 32'h001, 32'h101, 32'h201, 32'h301};
`else
    exp_q = '{32'h000, 32'h001, 32'h100, 32'h101, 32'h200, 32'h201, 32'h300, 32'h301};
`endif
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    stall = 1'b1;
    for (int e = 0; e < 2; e++) begin
      for (int ch = 0; ch < 4; ch++)
        set_src(ch, 32'h1000 + 32'(16 * ch + 4 * e), 5'(ch + 1), 1'b0, 1'b0, 32'(256 * ch + e));
      step();
    end
    clear_src();
    total++;
    if (src_ready !== 4'b0000) begin
      bad++; $display("FAIL arb_all_full got=%b want=0000", src_ready);
    end
    stall = 1'b0;
    step();
    for (int n = 0; n < 8; n++) begin
      total++;
      if ({pc_valid, wb_data} !== {1'b1, exp_q[n]}) begin
        bad++; $display("FAIL arb_order[%0d] got v=%0b data=%h want v=1 data=%h", n, pc_valid, wb_data, exp_q[n]);
      end
      step();
    end
    total++;
    if (pc_valid !== 1'b0) begin
      bad++; $display("FAIL arb_drained got=%0b want=0", pc_valid);
    end
  endtask

  task automatic test_flush();
    set_src(3, 32'h0000_0500, 5'd10, 1'b0, 1'b0, 32'h0000_5555);
    step();
    clear_src();
    step();
    stall = 1'b1;
    set_src(0, 32'h0000_0600, 5'd11, 1'b0, 1'b0, 32'h0000_00A0);
    set_src(1, 32'h0000_0604, 5'd12, 1'b0, 1'b0, 32'h0000_00A1);
    set_src(2, 32'h0000_0608, 5'd13, 1'b0, 1'b0, 32'h0000_00A2);
    step();
    clear_src();
    total++;
    if ({pc_valid, wb_data} !== {1'b1, 32'h0000_5555}) begin
      bad++; $display("FAIL flush_pre_hold got v=%0b data=%h want v=1 data=00005555", pc_valid, wb_data);
    end
    flush = 1'b1;
    set_src(0, 32'h0000_0700, 5'd14, 1'b0, 1'b0, 32'h0000_00A9);
    step();
    flush = 1'b0;
    stall = 1'b0;
    clear_src();
    total++;
    if ({pc_valid, reg_wr_en, freg_wr_en} !== 3'b000) begin
      bad++; $display("FAIL flush_out got v/reg/freg=%b want=000", {pc_valid, reg_wr_en, freg_wr_en});
    end
    total++;
    if (src_ready !== 4'b1111) begin
      bad++; $display("FAIL flush_ready got=%b want=1111", src_ready);
    end
    for (int n = 0; n < 4; n++) begin
      step();
      total++;
      if (pc_valid !== 1'b0) begin
        bad++; $display("FAIL flush_no_retire[%0d] got v=%0b data=%h want v=0", n, pc_valid, wb_data);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_x0_fp();
    test_exception();
    test_backpressure();
    test_arbitration();
    test_flush();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
